// File: rtl/cart_loader_pkg.sv
// Shared state type and size arithmetic for the cartridge download engine.
package cart_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StFill,
    StDone
  } state_e;

  // Smallest power of two >= size, capped at 2**aw; a zero size maps to zero.
  function automatic logic [31:0] ceil_pow2(input logic [31:0] size, input int unsigned aw);
    logic [31:0] result;
    logic [31:0] pow;
    logic        found;
    result = '0;
    found  = 1'b0;
    if (size != '0) begin
      for (int unsigned i = 0; i < 32; i++) begin
        pow = 32'd1 << i;
        if (!found && (i <= aw) && (pow >= size)) begin
          result = pow;
          found  = 1'b1;
        end
      end
      if (!found) begin
        result = 32'd1 << aw;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cart_loader.sv
// Cartridge download engine: ioctl byte stream to RAM write port through a one-entry
// buffer, with size tracking and optional power-of-two padding after the download.
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int unsigned AW         = 13,
  parameter logic [7:0]  SLOT_INDEX = 8'd1,
  parameter bit          PAD_P2     = 1'b1,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic [AW:0]   cart_size,
  output logic [AW:0]   cart_size_p2,
  output logic          busy,
  output logic          load_done,
  output logic          overflow
);

  localparam logic [AW:0] MaxSize = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic          dl_q;
  logic          buf_full_q, buf_full_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]    buf_data_q, buf_data_d;
  logic [AW:0]   cart_size_q, cart_size_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] fill_cnt_q, fill_cnt_d;

  logic          rise_match;
  logic          fall;
  logic          in_range;
  logic          write_ok;
  logic          in_fill;
  logic          start;
  logic [AW:0]   wr_size;
  logic [AW:0]   fill_last;

  assign rise_match = ioctl_download & ~dl_q & (ioctl_index == SLOT_INDEX);
  assign fall       = ~ioctl_download & dl_q;
  assign in_range   = (ioctl_addr[24:AW] == '0);
  assign wr_size    = {1'b0, ioctl_addr[AW-1:0]} + (AW+1)'(1);
  assign in_fill    = (state_q == StFill);
  assign write_ok   = mem_we & mem_ready;

  assign cart_size_p2 = (AW+1)'(ceil_pow2(32'(cart_size_q), AW));
  assign fill_last    = cart_size_p2 - (AW+1)'(1);

  // A matching download edge restarts the engine from any non-LOAD state.
  assign start = rise_match & (state_q != StLoad);

  always_comb begin
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    cart_size_d = cart_size_q;
    overflow_d  = overflow_q;
    fill_cnt_d  = fill_cnt_q;

    unique case (state_q)
      StIdle: begin
      end

      StLoad: begin
        if (write_ok) begin
          buf_full_d = 1'b0;
        end
        // Bytes arriving while the buffer is occupied are dropped silently.
        if (ioctl_download && ioctl_wr && !buf_full_q) begin
          if (in_range) begin
            buf_full_d = 1'b1;
            buf_addr_d = ioctl_addr[AW-1:0];
            buf_data_d = ioctl_dout;
            if (wr_size > cart_size_q) begin
              cart_size_d = wr_size;
            end
          end else begin
            overflow_d  = 1'b1;
            cart_size_d = MaxSize;
          end
        end
        if (fall) begin
          state_d = StDrain;
        end
      end

      StDrain: begin
        if (write_ok) begin
          buf_full_d = 1'b0;
        end
        if (!buf_full_q) begin
          if (PAD_P2 && (cart_size_q != '0) && (cart_size_q != cart_size_p2)) begin
            state_d    = StFill;
            fill_cnt_d = cart_size_q[AW-1:0];
          end else begin
            state_d = StDone;
          end
        end
      end

      StFill: begin
        if (mem_ready) begin
          if ({1'b0, fill_cnt_q} == fill_last) begin
            state_d = StDone;
          end else begin
            fill_cnt_d = fill_cnt_q + AW'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (start) begin
      state_d     = StLoad;
      buf_full_d  = 1'b0;
      cart_size_d = '0;
      overflow_d  = 1'b0;
      fill_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dl_q        <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      cart_size_q <= '0;
      overflow_q  <= 1'b0;
      fill_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dl_q        <= ioctl_download;
      buf_full_q  <= buf_full_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      cart_size_q <= cart_size_d;
      overflow_q  <= overflow_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  always_comb begin
    mem_we     = buf_full_q | in_fill;
    mem_addr   = in_fill ? fill_cnt_q : buf_addr_q;
    mem_data   = in_fill ? FILL_BYTE : buf_data_q;
    ioctl_wait = buf_full_q;
    busy       = (state_q != StIdle);
    load_done  = (state_q == StDone);
    cart_size  = cart_size_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_cart_loader.sv
// Randomized bench for cart_loader: drives ioctl downloads, logs RAM writes and compares
// them with an image model built from address/size rules.
module tb_cart_loader;

  localparam int unsigned AW  = 13;
  localparam int unsigned Cap = 1 << AW;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we;
  logic          mem_ready;
  logic [AW:0]   cart_size;
  logic [AW:0]   cart_size_p2;
  logic          busy;
  logic          load_done;
  logic          overflow;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  logic [20:0]   wr_log[$];
  int unsigned   dl_addr[$];
  logic [7:0]    dl_data[$];
  int unsigned   cyc = 0;
  int unsigned   we_age = 0;
  int unsigned   age_nxt = 0;
  int unsigned   stall_cycles = 0;
  int unsigned   wait_cyc = 0;
  int unsigned   done_cnt = 0;
  int unsigned   done_cyc = 0;
  int unsigned   done_log_len = 0;
  int unsigned   model_size = 0;
  bit            busy_seen = 1'b0;

  cart_loader #(
    .AW        (AW),
    .SLOT_INDEX(8'd1),
    .PAD_P2    (1'b1),
    .FILL_BYTE (8'hFF)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_we        (mem_we),
    .mem_ready     (mem_ready),
    .cart_size     (cart_size),
    .cart_size_p2  (cart_size_p2),
    .busy          (busy),
    .load_done     (load_done),
    .overflow      (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM model: refuses each pending write for stall_cycles cycles, then accepts it.
  assign mem_ready = (we_age >= stall_cycles);

  always @(posedge clk_sys) begin
    cyc    <= cyc + 1;
    we_age <= age_nxt;
  end

  always @(negedge clk_sys) begin
    if (mem_we && mem_ready) begin
      wr_log.push_back({mem_addr, mem_data});
      age_nxt = 0;
    end else if (mem_we) begin
      age_nxt = we_age + 1;
    end else begin
      age_nxt = 0;
    end
    if (ioctl_wait) wait_cyc++;
    if (busy) busy_seen = 1'b1;
    if (load_done) begin
      done_cnt++;
      done_cyc     = cyc;
      done_log_len = wr_log.size();
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic build_seq(input int unsigned base, input int unsigned n);
    dl_addr.delete();
    dl_data.delete();
    for (int unsigned i = 0; i < n; i++) begin
      dl_addr.push_back(base + i);
      dl_data.push_back(8'($urandom));
    end
  endtask

  task automatic build_rand(input int unsigned n, input int unsigned span, input int unsigned oor_pct);
    dl_addr.delete();
    dl_data.delete();
    for (int unsigned i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < oor_pct) dl_addr.push_back($urandom_range(Cap, 32'h1FF_FFFF));
      else dl_addr.push_back($urandom_range(0, span - 1));
      dl_data.push_back(8'($urandom));
    end
  endtask

  task automatic dl_begin(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic dl_send();
    int unsigned guard;
    for (int unsigned i = 0; i < dl_addr.size(); i++) begin
      ioctl_addr = 25'(dl_addr[i]);
      ioctl_dout = dl_data[i];
      ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      guard = 0;
      while (ioctl_wait && guard < 64) begin
        @(posedge clk_sys); #1;
        guard++;
      end
      if (guard >= 64) check_eq("wait_timeout", guard, 0);
    end
  endtask

  task automatic dl_end(output int unsigned fall_cyc);
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    fall_cyc       = cyc;
  endtask

  task automatic wait_log(input int unsigned n);
    int unsigned guard;
    guard = 0;
    while (wr_log.size() < n && guard < 20000) begin
      @(posedge clk_sys); #1;
      guard++;
    end
    if (guard >= 20000) check_eq("log_timeout", wr_log.size(), n);
  endtask

  // Model: in-range bytes land in order, size is the highest address + 1 (or full
  // capacity after an out-of-range byte), then FF fill up to the next power of two.
  task automatic run_download(input logic [7:0] idx, input int unsigned stall, input bit chk_lat);
    logic [20:0] exp_log[$];
    int unsigned size, p2, in_cnt, max_end, guard, fall_cyc, err0;
    bit          ovf, match;
    match   = (idx == 8'd1);
    in_cnt  = 0;
    max_end = 0;
    ovf     = 1'b0;
    for (int unsigned i = 0; i < dl_addr.size(); i++) begin
      if (dl_addr[i] < Cap) begin
        exp_log.push_back({AW'(dl_addr[i]), dl_data[i]});
        in_cnt++;
        if (dl_addr[i] + 1 > max_end) max_end = dl_addr[i] + 1;
      end else begin
        ovf = 1'b1;
      end
    end
    size = ovf ? Cap : max_end;
    p2   = 0;
    if (size != 0) begin
      p2 = 1;
      while (p2 < size) p2 = p2 * 2;
    end
    if (size != 0 && size != p2) begin
      for (int unsigned a = size; a < p2; a++) exp_log.push_back({AW'(a), 8'hFF});
    end

    stall_cycles = stall;
    wait_cyc     = 0;
    done_cnt     = 0;
    busy_seen    = 1'b0;
    dl_begin(idx);
    wr_log.delete();
    if (match) begin
      check_eq("start_busy", busy, 1);
      check_eq("start_size_clear", cart_size, 0);
      check_eq("start_ovf_clear", overflow, 0);
    end
    dl_send();
    dl_end(fall_cyc);

    if (match) begin
      guard = 0;
      while (done_cnt == 0 && guard < 20000) begin
        @(posedge clk_sys); #1;
        guard++;
      end
      if (guard >= 20000) check_eq("done_timeout", guard, 0);
      repeat (4) @(posedge clk_sys);
      #1;
      check_eq("done_pulses", done_cnt, 1);
      if (chk_lat) check_eq("done_latency", done_cyc - fall_cyc, 2);
      check_eq("done_after_last_wr", done_log_len, exp_log.size());
      check_eq("wr_count", wr_log.size(), exp_log.size());
      for (int unsigned i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
        err0 = n_errors;
        check_eq("wr_entry", 32'(wr_log[i]), 32'(exp_log[i]));
        if (n_errors != err0) break;
      end
      check_eq("cart_size", cart_size, size);
      check_eq("cart_size_p2", cart_size_p2, p2);
      check_eq("overflow", overflow, 32'(ovf));
      check_eq("wait_cycles", wait_cyc, in_cnt * (stall + 1));
      check_eq("idle_after_done", busy, 0);
      model_size = size;
    end else begin
      repeat (10) @(posedge clk_sys);
      #1;
      check_eq("ignored_wr_count", wr_log.size(), 0);
      check_eq("ignored_busy", 32'(busy_seen), 0);
      check_eq("ignored_done", done_cnt, 0);
      check_eq("ignored_keeps_size", cart_size, model_size);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned fall_cyc;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_wait", ioctl_wait, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_data", mem_data, 0);
    check_eq("rst_size", cart_size, 0);
    check_eq("rst_size_p2", cart_size_p2, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", load_done, 0);
    check_eq("rst_ovf", overflow, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;

    // Exact power-of-two image: no fill, fixed done latency.
    build_seq(0, 4096);
    run_download(8'd1, 0, 1'b1);

    // 6 KiB image padded to 8 KiB.
    build_seq(0, 6144);
    run_download(8'd1, 0, 1'b0);

    // Slow RAM: three refused cycles per write.
    build_rand(48, Cap, 0);
    run_download(8'd1, 3, 1'b0);

    // Other slot: must be ignored entirely.
    build_rand(20, 1000, 0);
    run_download(8'd2, 0, 1'b0);

    // Capacity boundary.
    dl_addr.delete();
    dl_data.delete();
    dl_addr.push_back(Cap - 2);
    dl_addr.push_back(Cap - 1);
    dl_addr.push_back(Cap);
    for (int unsigned i = 0; i < 3; i++) dl_data.push_back(8'($urandom));
    run_download(8'd1, 0, 1'b0);

    for (int unsigned r = 0; r < 3; r++) begin
      build_rand($urandom_range(1, 300), 3000, 10);
      run_download(8'd1, $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of padding.
    build_seq(0, 6144);
    stall_cycles = 0;
    done_cnt     = 0;
    dl_begin(8'd1);
    wr_log.delete();
    dl_send();
    dl_end(fall_cyc);
    wait_log(6144 + 100);
    reset = 1'b1;
    @(negedge clk_sys);
    check_eq("rst_fill_busy", busy, 0);
    check_eq("rst_fill_we", mem_we, 0);
    check_eq("rst_fill_size", cart_size, 0);
    check_eq("rst_fill_done", load_done, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk_sys);
    #1;
    check_eq("rst_fill_no_done", done_cnt, 0);
    check_eq("rst_fill_idle", busy, 0);
    check_eq("rst_fill_size_after", cart_size, 0);
    model_size = 0;

    // Matching download arriving mid-fill aborts and restarts.
    build_seq(0, 1000);
    done_cnt = 0;
    dl_begin(8'd1);
    wr_log.delete();
    dl_send();
    dl_end(fall_cyc);
    wait_log(1000 + 5);
    check_eq("abort_in_fill_busy", busy, 1);
    check_eq("abort_in_fill_we", mem_we, 1);
    check_eq("abort_no_done_yet", done_cnt, 0);
    build_rand(100, 500, 0);
    run_download(8'd1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
